control_fsm: RTL and testbench

Multicycle control unit for the RISC-V core: decodes the current instruction word and sequences the datapath through fetch, decode, execute, memory and write-back states. It is the counterpart of the datapath. It consumes `instr` and `Zero`, and drives `PCSrc`, `ALUSrc`, `RegWrite`, `MemToReg`, `ALUCtrl` and `loadPC`, plus the data-memory request/ready handshake and a retired-instruction counter.

---
 rtl/riscv_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 48 ++++
 rtl/control_fsm.sv | 154 +++++++++++++++
 tb/tb_control_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V multicycle control unit: opcodes,
// ALU operation codes, FSM state encoding and instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NONE
  } instr_class_t;

  // Map an opcode onto the instruction class; anything unknown is CLS_NONE.
  function automatic instr_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:  return CLS_R;
      OP_IALU:   return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

  // Classes whose second ALU operand is the immediate.
  function automatic logic uses_imm(input instr_class_t cls);
    return (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

  // Classes that write a destination register in WB.
  function automatic logic writes_rd(input instr_class_t cls);
    return (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_LOAD);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: {class, funct3, funct7[5]} -> ALUCtrl.
// Kept free of state so a pipelined control unit can reuse it unchanged.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  instr_class_t cls,
  input  logic [2:0]   funct3,
  input  logic         funct7_b5,
  output logic [3:0]   alu_ctrl
);

  // Select the ALU operation; funct7[5] only matters for sub/sra/srai.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (cls)
      CLS_R: begin
        case (funct3)
          3'b000:  alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_I: begin
        // addi has no sub form: bit 30 is an immediate bit there.
        case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_LOAD:   alu_ctrl = ALU_ADD;
      CLS_STORE:  alu_ctrl = ALU_ADD;
      CLS_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V control unit: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// All control outputs are registered and reflect the current state.
// Optional feature macro ILLEGAL_TRAP_EN: unsupported opcodes halt the FSM
// and raise `illegal`; without it they retire as NOPs.
module control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 Zero,
  input  logic                 dReady,
  output logic                 PCSrc,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic [3:0]           ALUCtrl,
  output logic                 loadPC,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t       state;
  instr_class_t cls_d;
  instr_class_t cls_q;
  logic [3:0]   alu_d;
  logic [3:0]   alu_q;
  logic         zero_q;
  logic         branch_taken;
  logic         unused_instr_bits;

  assign cls_d = classify(instr[6:0]);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .cls       (cls_d),
    .funct3    (instr[14:12]),
    .funct7_b5 (instr[30]),
    .alu_ctrl  (alu_d)
  );

  // Zero is still being captured on the EXEC->WB edge, so take it directly there.
  assign branch_taken = (cls_q == CLS_BRANCH) && ((state == ST_EXEC) ? Zero : zero_q);

  // Decoded instruction fields and the ALU flag; no reset needed on these.
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      cls_q <= cls_d;
      alu_q <= alu_d;
    end
    if (state == ST_EXEC) begin
      zero_q <= Zero;
    end
  end

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // State sequencing with outputs registered for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      PCSrc    <= 1'b0;
      ALUSrc   <= 1'b0;
      RegWrite <= 1'b0;
      MemToReg <= 1'b0;
      ALUCtrl  <= 4'b0000;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      instret  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      PCSrc    <= 1'b0;
      ALUSrc   <= 1'b0;
      RegWrite <= 1'b0;
      MemToReg <= 1'b0;
      ALUCtrl  <= 4'b0000;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          if (cls_d == CLS_NONE) begin
            state   <= ST_HALT;
            illegal <= 1'b1;
          end else begin
            state   <= ST_EXEC;
            ALUSrc  <= uses_imm(cls_d);
            ALUCtrl <= alu_d;
          end
`else
          state   <= ST_EXEC;
          ALUSrc  <= uses_imm(cls_d);
          ALUCtrl <= alu_d;
`endif
        end
        ST_EXEC: begin
          ALUSrc  <= uses_imm(cls_q);
          ALUCtrl <= alu_q;
          if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
            state    <= ST_MEM;
            MemRead  <= (cls_q == CLS_LOAD);
            MemWrite <= (cls_q == CLS_STORE);
            MemToReg <= (cls_q == CLS_LOAD);
          end else begin
            state    <= ST_WB;
            loadPC   <= 1'b1;
            RegWrite <= writes_rd(cls_q);
            PCSrc    <= branch_taken;
          end
        end
        ST_MEM: begin
          ALUSrc   <= uses_imm(cls_q);
          ALUCtrl  <= alu_q;
          MemToReg <= (cls_q == CLS_LOAD);
          if (dReady) begin
            state    <= ST_WB;
            loadPC   <= 1'b1;
            RegWrite <= writes_rd(cls_q);
            PCSrc    <= branch_taken;
          end else begin
            MemRead  <= (cls_q == CLS_LOAD);
            MemWrite <= (cls_q == CLS_STORE);
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          instret <= instret + 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        ST_HALT: begin
          state <= ST_HALT;
        end
`endif
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed table-driven bench for control_fsm, plus hand-written sequences
// for reset during a stalled load and (with ILLEGAL_TRAP_EN) the halt path.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        dReady = 1'b0;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [31:0] instret;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_instret = 32'd0;

  control_fsm #(.INSTRET_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .Zero     (Zero),
    .dReady   (dReady),
    .PCSrc    (PCSrc),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .ALUCtrl  (ALUCtrl),
    .loadPC   (loadPC),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .illegal  (illegal),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    bit          zero;
    int          n_wait;
    logic [3:0]  alu;
    bit          care_alu;
    bit          src;
    bit          regw;
    bit          pcsrc;
    bit          memrd;
    bit          memwr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [31:0] ins, bit zero, int n_wait,
                              logic [3:0] alu, bit care_alu, bit src, bit regw,
                              bit pcsrc, bit memrd, bit memwr);
    vec_t v;
    v.name = name; v.instr = ins; v.zero = zero; v.n_wait = n_wait;
    v.alu = alu; v.care_alu = care_alu; v.src = src; v.regw = regw;
    v.pcsrc = pcsrc; v.memrd = memrd; v.memwr = memwr;
    return v;
  endfunction

  // {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl[3:0], loadPC, MemRead, MemWrite, illegal}
  function automatic logic [11:0] obs();
    return {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal};
  endfunction

  task automatic check_bits(input string name, input logic [11:0] act,
                            input logic [11:0] exp, input logic [11:0] mask);
    n_chk++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: outputs {pc,src,rw,m2r,alu,ldpc,mr,mw,ill} got %b, expected %b (mask %b)",
               name, act, exp, mask);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: instret got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Run the first ncyc cycles of one instruction; cycle 1 is FETCH.
  task automatic run_cycles(input vec_t v, input int ncyc);
    bit          ismem;
    int          lat;
    logic [11:0] e;
    logic [11:0] mask;
    ismem = v.memrd || v.memwr;
    lat   = ismem ? (5 + v.n_wait) : 4;
    mask  = v.care_alu ? 12'hFFF : 12'b1011_0000_1111;
    for (int c = 1; c <= ncyc; c++) begin
      instr  = v.instr;
      Zero   = v.zero;
      dReady = ismem ? (c >= 4 + v.n_wait) : 1'b1;
      @(negedge clk);
      e = '0;
      e[11]  = v.pcsrc && (c == lat);
      e[10]  = v.src && (c >= 3);
      e[9]   = v.regw && (c == lat);
      e[8]   = v.memrd && (c >= 4);
      e[7:4] = (c >= 3) ? v.alu : 4'b0000;
      e[3]   = (c == lat);
      e[2]   = v.memrd && (c >= 4) && (c < lat);
      e[1]   = v.memwr && (c >= 4) && (c < lat);
      e[0]   = 1'b0;
      check_bits($sformatf("%s cyc%0d", v.name, c), obs(), e, mask);
      if (c == 1 || c == lat)
        check_cnt($sformatf("%s instret cyc%0d", v.name, c), instret, exp_instret);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    lat = (v.memrd || v.memwr) ? (5 + v.n_wait) : 4;
    run_cycles(v, lat);
    exp_instret = exp_instret + 32'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //        name        instr          Z  wait alu      care src rw pc mr mw
    vecs.push_back(mk("add",     32'h002081B3, 1, 0, 4'b0010, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("sub",     32'h402081B3, 0, 0, 4'b0110, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("sra",     32'h4020D1B3, 0, 0, 4'b1010, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("sll",     32'h002091B3, 0, 0, 4'b1001, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("and",     32'h0020F1B3, 0, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("or",      32'h0020E1B3, 0, 0, 4'b0001, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("slt",     32'h0020A1B3, 0, 0, 4'b0111, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("srai",    32'h4020D193, 0, 0, 4'b1010, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("srli",    32'h0020D193, 0, 0, 4'b1000, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("xori",    32'h0050C193, 0, 0, 4'b1101, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("addi1024",32'h40008193, 1, 0, 4'b0010, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("lw_w2",   32'h0080A283, 0, 2, 4'b0010, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk("lw_w0",   32'h0080A283, 0, 0, 4'b0010, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk("sw_w0",   32'h0020A223, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("sw_w3",   32'h0020A223, 1, 3, 4'b0010, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("beq_z1",  32'h00208463, 1, 0, 4'b0110, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("beq_z0",  32'h00208463, 0, 0, 4'b0110, 1, 0, 0, 0, 0, 0));
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back(mk("nop_ill", 32'hFFFFFFFF, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
`endif

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bits("reset outputs", obs(), 12'h000, 12'hFFF);
    check_cnt("reset instret", instret, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during MEM of a stalled load, then rerun the load
    v = mk("lw_stall", 32'h0080A283, 0, 5, 4'b0010, 1, 1, 1, 0, 1, 0);
    run_cycles(v, 5);
    #2;
    rst = 1'b0;
    #1;
    check_bits("mid-reset outputs", obs(), 12'h000, 12'hFFF);
    check_cnt("mid-reset instret", instret, 32'd0);
    exp_instret = 32'd0;
    @(posedge clk);
    #1;
    check_bits("held-reset outputs", obs(), 12'h000, 12'hFFF);
    rst = 1'b1;
    run_vec(mk("lw_rerun", 32'h0080A283, 0, 1, 4'b0010, 1, 1, 1, 0, 1, 0));
    check_cnt("post-rerun instret", instret, 32'd1);

`ifdef ILLEGAL_TRAP_EN
    // Unsupported opcode halts with illegal set from cycle 3 onward
    for (int c = 1; c <= 8; c++) begin
      instr  = 32'hFFFFFFFF;
      Zero   = 1'b1;
      dReady = 1'b1;
      @(negedge clk);
      check_bits($sformatf("trap cyc%0d", c), obs(), {11'b0, (c >= 3)}, 12'hFFF);
      check_cnt($sformatf("trap instret cyc%0d", c), instret, exp_instret);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_bits("trap reset outputs", obs(), 12'h000, 12'hFFF);
    exp_instret = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk("add_after_trap", 32'h002081B3, 0, 0, 4'b0010, 1, 0, 1, 0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
